decoder_onehot_seq: RTL and testbench
=====================================

// Module: decoder_onehot_seq
// PURPOSE
//  Parametrised, registered N-to-2^N one-hot decoder with a valid/ready request port.
//  Generalises the combinational 4-to-16 decoder:
//   - select width is a parameter;
//   - output is registered;
//   - two output modes: HOLD (level) and PULSE (timed strobe).
//  Drives chip-select / strobe lines for downstream peripherals from a single request stream.
// PARAMETERS
//  SEL_W      4   select width; output width OUT_W = 2**SEL_W (localparam); legal 1..8
//  PULSE_LEN  4   cycles the selected line stays high in PULSE mode; legal >= 1
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  en         in   1        global enable; 0 forces outputs low and aborts activity
//  in_valid   in   1        request valid
//  in_ready   out  1        block can accept a request this cycle
//  in_sel     in   SEL_W    index of the line to assert
//  in_mode    in   1        0 = HOLD, 1 = PULSE; sampled with the request
//  out        out  OUT_W    registered one-hot (or all-zero) decode
//  busy       out  1        PULSE strobe in progress
//  done       out  1        1-cycle pulse when a PULSE strobe completes normally
// BEHAVIOUR
//  Reset:
//   - rst=1 at a clock edge: out=0, busy=0, done=0, counter=0, FSM=IDLE.
//   - in_ready=0 while rst=1.
//  Accept: a request is accepted when in_valid && in_ready at a clock edge.
//  Ready: in_ready = en && !rst && (state==IDLE || state==HOLD).
//  FSM states: IDLE, HOLD, PULSE.
//  IDLE:
//   - out=0.
//   - Accept with in_mode=0 -> HOLD.
//   - Accept with in_mode=1 -> PULSE.
//  HOLD:
//   - out = 1<<sel, held indefinitely.
//   - A new accept replaces out on the next edge (no intermediate zero cycle).
//   - The new accept may switch mode.
//  PULSE:
//   - out = 1<<sel for exactly PULSE_LEN cycles, then out=0 and -> IDLE.
//   - done=1 during the first cycle after out drops.
//   - busy=1 for all PULSE_LEN cycles.
//   - in_ready=0 throughout; new requests stall.
//  Latency: out changes on the edge that accepts the request (visible the following cycle). One cycle total.
//  Counter: width $clog2(PULSE_LEN+1). It loads PULSE_LEN-1 on accept and decrements each cycle. The strobe ends when the counter reaches 0 with state==PULSE.
//  en=0 at an edge, in any state:
//   - out=0, busy=0, FSM -> IDLE.
//   - An in-progress pulse is aborted with done=0.
//   - No request is accepted.
//  done is never asserted with busy in the same cycle. Back-to-back PULSE requests therefore have a minimum of one idle cycle between strobes.
//  Every SEL_W-bit select value is legal (full 2**SEL_W range); there is no out-of-range case.
//  Invariant: out is always zero or exactly one-hot.
// CONFIGURATION
//  DECODER_ONEHOT_CHECK_EN defined:
//   - Adds output port onehot_err (1 bit), sticky.
//   - Set at the first edge where out has more than one bit high, or busy=1 with out=0.
//   - Cleared only by rst.
//  Not defined: port and check logic are absent; all other behaviour is identical.
// TESTING  (SEL_W=4, PULSE_LEN=3 unless stated)
//  1 Reset: hold rst 2 cycles with in_valid=1 -> out=16'h0000, in_ready=0, busy=0, done=0.
//  2 HOLD replace: accept sel=5 mode=0, then sel=12 mode=0 next cycle
//    -> out=16'h0020 for 1 cycle, then 16'h1000 held; in_ready stays 1.
//  3 PULSE timing: accept sel=15 mode=1
//    -> out=16'h8000 and busy=1 for exactly 3 cycles; then out=0, done=1 for 1 cycle;
//       in_ready=0 during the strobe; a request held valid meanwhile is accepted the cycle after done.
//  4 Abort: accept sel=3 mode=1, drop en in the 2nd strobe cycle
//    -> next edge out=0, busy=0, done never asserts, in_ready=0 until en=1.
//  5 Sweep: SEL_W=3 and SEL_W=4 builds, all sel values in HOLD mode
//    -> out == 1<<sel each time and a bench one-hot checker never fires; PULSE_LEN=1 build gives 1-cycle strobes.
//  6 Check macro: build with DECODER_ONEHOT_CHECK_EN and run scenarios 2-4 -> onehot_err remains 0.

Source files
------------

// File: rtl/decoder_onehot_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decoder_onehot_seq                                         |
// | Description : Registered SEL_W-to-2**SEL_W one-hot decoder with a        |
// |               valid/ready request port, HOLD (level) and PULSE (timed    |
// |               strobe) modes. Optional sticky one-hot checker enabled by  |
// |               defining DECODER_ONEHOT_CHECK_EN (adds port onehot_err).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module decoder_onehot_seq #(
  parameter int SEL_W     = 4,
  parameter int PULSE_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_mode,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic                    busy,
  output logic                    done
`ifdef DECODER_ONEHOT_CHECK_EN
  ,
  output logic                    onehot_err
`endif
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [OUT_W-1:0]   r_out,   w_out_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_done,  w_done_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               w_accept;
  logic [OUT_W-1:0]   w_dec;

  assign in_ready = en && !rst && (r_state != ST_PULSE);
  assign w_accept = in_valid && in_ready;
  assign w_dec    = OUT_W'(1) << in_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    if (!en) begin
      // Dropping enable aborts any strobe silently (no done).
      w_state_nxt = ST_IDLE;
      w_out_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            w_out_nxt = w_dec;
            if (in_mode) begin
              w_state_nxt = ST_PULSE;
              w_busy_nxt  = 1'b1;
              w_cnt_nxt   = C_CNT_LOAD;
            end else begin
              w_state_nxt = ST_HOLD;
              w_busy_nxt  = 1'b0;
            end
          end else if (r_state == ST_IDLE) begin
            w_out_nxt = '0;
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_out_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

`ifdef DECODER_ONEHOT_CHECK_EN
  logic r_onehot_err;
  logic w_err_cond;

  // x & (x-1) is non-zero exactly when more than one bit of x is set.
  assign w_err_cond = ((r_out & (r_out - OUT_W'(1))) != '0) || (r_busy && (r_out == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_onehot_err <= 1'b0;
    end else if (w_err_cond) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign onehot_err = r_onehot_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_onehot_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_decoder_onehot_seq                                      |
// | Description : Self-checking bench for decoder_onehot_seq (SEL_W=4,       |
// |               PULSE_LEN=3 main instance; SEL_W=3, PULSE_LEN=1 second).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_decoder_onehot_seq;

  localparam int SEL_W     = 4;
  localparam int PULSE_LEN = 3;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_mode, in_ready, busy, done;
  logic [3:0]  in_sel;
  logic [15:0] out;
  logic        v3, mode3, ready3, busy3, done3;
  logic [2:0]  sel3;
  logic [7:0]  out3;
`ifdef DECODER_ONEHOT_CHECK_EN
  logic        onehot_err, err3;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural reference: remaining strobe cycles counted directly.
  logic [15:0] m_out  = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;

  always #5 clk = ~clk;

  decoder_onehot_seq #(.SEL_W(SEL_W), .PULSE_LEN(PULSE_LEN)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_mode(in_mode), .out(out), .busy(busy), .done(done)
`ifdef DECODER_ONEHOT_CHECK_EN
    , .onehot_err(onehot_err)
`endif
  );

  decoder_onehot_seq #(.SEL_W(3), .PULSE_LEN(1)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(v3), .in_ready(ready3),
    .in_sel(sel3), .in_mode(mode3), .out(out3), .busy(busy3), .done(done3)
`ifdef DECODER_ONEHOT_CHECK_EN
    , .onehot_err(err3)
`endif
  );

  function automatic logic m_ready();
    return en && !rst && !m_busy;
  endfunction

  task automatic model_edge();
    if (rst || !en) begin
      m_out = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        m_out = '0; m_busy = 1'b0;
      end
    end else if (in_valid) begin
      m_out  = 16'(1) << in_sel;
      m_busy = in_mode;
      m_left = in_mode ? PULSE_LEN : 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_sel = 4'd7; in_mode = 1'b0;
    v3 = 1'b0; sel3 = '0; mode3 = 1'b0;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", in_ready);
    if (in_ready !== 1'b0) errors++;
    checks++;
    if ({out, busy, done} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs: out=%h busy=%b done=%b expected 0/0/0", out, busy, done);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold_replace();
    in_valid = 1'b1; in_sel = 4'd5; in_mode = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready0: got %b expected 1", in_ready); end
    tick();
    checks++;
    if (out !== 16'h0020) begin errors++; $display("FAIL hold_first: got %h expected 0020", out); end
    in_sel = 4'd12; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready1: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out !== 16'h1000 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL hold_second: out=%h busy=%b ready=%b expected 1000/0/1", out, busy, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_pulse_timing();
    in_valid = 1'b1; in_sel = 4'd15; in_mode = 1'b1;
    tick();
    in_sel = 4'd2; in_mode = 1'b0;
    for (int i = 0; i < PULSE_LEN; i++) begin
      checks++;
      if (out !== 16'h8000 || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL pulse_cycle%0d: out=%h busy=%b done=%b ready=%b expected 8000/1/0/0", i, out, busy, done, in_ready);
      end
      tick();
    end
    checks++;
    if (out !== 16'h0 || busy !== 1'b0 || done !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pulse_done: out=%h busy=%b done=%b ready=%b expected 0000/0/1/1", out, busy, done, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out !== 16'h0004 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL pulse_next_accept: out=%h done=%b busy=%b expected 0004/0/0", out, done, busy);
    end
    tick();
  endtask

  task automatic test_abort();
    in_valid = 1'b1; in_sel = 4'd3; in_mode = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out !== 16'h0008 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_strobe: out=%h busy=%b expected 0008/1", out, busy);
    end
    tick();
    en = 1'b0; in_valid = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL abort_cycle%0d: out=%h busy=%b done=%b ready=%b expected 0/0/0/0", i, out, busy, done, in_ready);
      end
    end
    en = 1'b1; in_valid = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_resume: ready=%b expected 1", in_ready); end
    tick();
    checks++;
    if (done !== 1'b0 || out !== 16'h0) begin errors++; $display("FAIL abort_no_done: done=%b out=%h expected 0/0", done, out); end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 16; s++) begin
      in_valid = 1'b1; in_mode = 1'b0; in_sel = 4'(s);
      v3 = (s < 8); sel3 = 3'(s); mode3 = 1'b0;
      tick();
      checks++;
      if (out !== (16'(1) << s) || !$onehot(out)) begin
        errors++; $display("FAIL sweep4_sel%0d: got %h expected %h", s, out, 16'(1) << s);
      end
      if (s < 8) begin
        checks++;
        if (out3 !== (8'(1) << s) || !$onehot(out3)) begin
          errors++; $display("FAIL sweep3_sel%0d: got %h expected %h", s, out3, 8'(1) << s);
        end
      end
    end
    in_valid = 1'b0;
    v3 = 1'b1; sel3 = 3'd6; mode3 = 1'b1;
    tick();
    v3 = 1'b0;
    checks++;
    if (out3 !== 8'h40 || busy3 !== 1'b1 || ready3 !== 1'b0) begin
      errors++; $display("FAIL len1_strobe: out=%h busy=%b ready=%b expected 40/1/0", out3, busy3, ready3);
    end
    tick();
    checks++;
    if (out3 !== 8'h00 || busy3 !== 1'b0 || done3 !== 1'b1) begin
      errors++; $display("FAIL len1_done: out=%h busy=%b done=%b expected 00/0/1", out3, busy3, done3);
    end
    tick();
    checks++;
    if (done3 !== 1'b0) begin errors++; $display("FAIL len1_done_width: done=%b expected 0", done3); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; rst = 1'b0; in_valid = 1'b1; in_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_sel = 4'($urandom); #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL b2b_ready%0d: got %b expected %b", i, in_ready, m_ready());
      end
      tick();
      checks++;
      if (out !== m_out || busy !== m_busy || done !== m_done || (done && busy)) begin
        errors++; $display("FAIL b2b_cycle%0d: out=%h busy=%b done=%b expected %h/%b/%b", i, out, busy, done, m_out, m_busy, m_done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      en       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_sel   = 4'($urandom);
      in_mode  = 1'($urandom);
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL rand_ready%0d: got %b expected %b", i, in_ready, m_ready());
      end
      tick();
      checks++;
      if (out !== m_out || busy !== m_busy || done !== m_done) begin
        errors++; $display("FAIL rand_cycle%0d: out=%h busy=%b done=%b expected %h/%b/%b", i, out, busy, done, m_out, m_busy, m_done);
      end
      checks++;
      if (!$onehot0(out) || (done && busy)) begin
        errors++; $display("FAIL rand_invariant%0d: out=%h busy=%b done=%b", i, out, busy, done);
      end
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_check_flag();
`ifdef DECODER_ONEHOT_CHECK_EN
    checks++;
    if (onehot_err !== 1'b0 || err3 !== 1'b0) begin
      errors++; $display("FAIL onehot_err: got %b/%b expected 0/0", onehot_err, err3);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_hold_replace();
    test_pulse_timing();
    test_abort();
    test_check_flag();
    test_sweep();
    test_back_to_back();
    test_random(400);
    test_check_flag();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
